// File: rtl/vram_burst_writer.sv
// vram_burst_writer: drains a first-word-fall-through write FIFO into an
// asynchronous SRAM (CY7C1049-class) using CE-framed, WE-controlled write
// cycles. Each word runs SETUP (1) -> WRITE (WE_CYCLES) -> HOLD (HOLD_CYCLES).
// Up to MAX_BURST words are chained per bus grant without releasing CE.
// All SRAM-facing outputs come straight from flops so the pins never glitch.
module vram_burst_writer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 19,
  parameter int WE_CYCLES   = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int MAX_BURST   = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     fifo_addr,
  input  logic [DATA_W-1:0]     fifo_data,
  input  logic [DATA_W/8-1:0]   fifo_be,
  input  logic                  empty,
  input  logic                  valid,
  output logic                  fifo_read,
  input  logic                  bus_free,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     dataBusOutput,
  output logic                  data_oe,
  output logic                  writeSignal,
  output logic                  chipEnable,
  output logic [DATA_W/8-1:0]   sram_be_n,
  output logic                  done,
  output logic [CNT_W-1:0]      words_written
);

  localparam int BE_W   = DATA_W / 8;
  localparam int BC_W   = $clog2(MAX_BURST) + 1;
  localparam int CYC_MX = (WE_CYCLES > HOLD_CYCLES) ? WE_CYCLES : HOLD_CYCLES;
  localparam int CC_W   = $clog2(CYC_MX) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CC_W-1:0]     cyc_q, cyc_d;
  logic [BC_W-1:0]     burst_q, burst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BE_W-1:0]     be_n_q, be_n_d;
  logic                fifo_read_q, fifo_read_d;
  logic                we_n_q, we_n_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_q, oe_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic                head_ok;

  assign head_ok = ~empty & valid;

  // Next-state logic: sequence one word at a time and chain words within a burst.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    data_d      = data_q;
    be_n_d      = be_n_q;
    fifo_read_d = 1'b0;
    words_d     = words_q;

    case (state_q)
      S_IDLE: begin
        // bus_free is only consulted here; an in-progress burst is never aborted
        if (head_ok && !bus_free) begin
          addr_d      = fifo_addr;
          data_d      = fifo_data;
          be_n_d      = ~fifo_be;
          fifo_read_d = 1'b1;
          burst_d     = '0;
          state_d     = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        cyc_d   = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (cyc_q == CC_W'(WE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_HOLD;
        end else begin
          cyc_d = cyc_q + CC_W'(1);
        end
      end
      S_HOLD: begin
        if (cyc_q == CC_W'(HOLD_CYCLES - 1)) begin
          cyc_d   = '0;
          words_d = words_q + CNT_W'(1);
          // chain straight into the next word while CE stays low
          if ((int'(burst_q) + 1 < MAX_BURST) && head_ok) begin
            addr_d      = fifo_addr;
            data_d      = fifo_data;
            be_n_d      = ~fifo_be;
            fifo_read_d = 1'b1;
            burst_d     = burst_q + BC_W'(1);
            state_d     = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin values are decoded from the next state so they can be registered.
    we_n_d = (state_d != S_WRITE);
    ce_n_d = (state_d == S_IDLE);
    oe_d   = (state_d != S_IDLE);
    done_d = (state_d == S_IDLE);
    if (state_d == S_IDLE) begin
      data_d = '0;
      be_n_d = '1;
    end else begin
      data_d = data_d;
    end
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      burst_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      be_n_q      <= '1;
      fifo_read_q <= 1'b0;
      we_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      done_q      <= 1'b1;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      burst_q     <= burst_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      be_n_q      <= be_n_d;
      fifo_read_q <= fifo_read_d;
      we_n_q      <= we_n_d;
      ce_n_q      <= ce_n_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      words_q     <= words_d;
    end
  end

  assign fifo_read     = fifo_read_q;
  assign sram_addr     = addr_q;
  assign dataBusOutput = data_q;
  assign data_oe       = oe_q;
  assign writeSignal   = we_n_q;
  assign chipEnable    = ce_n_q;
  assign sram_be_n     = be_n_q;
  assign done          = done_q;
  assign words_written = words_q;

endmodule

// File: doc/vram_burst_writer.md
# vram_burst_writer

Parametrised FIFO-to-VRAM write engine for the CY7C1049-class SRAM framebuffer. It drains address/data/byte-enable entries from a first-word-fall-through write FIFO and issues CE-framed, WE-controlled SRAM write cycles with configurable setup, pulse and hold lengths. When the framebuffer grants the bus, it writes a burst of up to MAX_BURST words. It sits between the host-side write FIFO and the shared VRAM bus, alongside the framebuffer scan-out reader.

## Interface
- DATA_W, 16, SRAM data width; must be a multiple of 8
- ADDR_W, 19, SRAM word address width
- WE_CYCLES, 2, cycles WE is held low per word; minimum 1
- HOLD_CYCLES, 1, cycles data and CE are held after WE rises; minimum 1
- MAX_BURST, 4, maximum words written per bus grant; minimum 1
- CNT_W, 16, width of the words_written counter
- clock  in  1  single system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- fifo_addr  in  ADDR_W  head-entry word address (FWFT)
- fifo_data  in  DATA_W  head-entry data (FWFT)
- fifo_be  in  DATA_W/8  head-entry byte enables; 1 = write that byte
- empty  in  1  1 = FIFO empty
- valid  in  1  1 = head entry valid
- fifo_read  out  1  one-cycle pop strobe
- bus_free  in  1  0 = framebuffer not using bus (write permitted); 1 = bus in use
- sram_addr  out  ADDR_W  SRAM address
- dataBusOutput  out  DATA_W  data to the tristate bus driver
- data_oe  out  1  1 = drive dataBusOutput onto the bus
- writeSignal  out  1  SRAM WE, active low
- chipEnable  out  1  SRAM CE, active low
- sram_be_n  out  DATA_W/8  SRAM byte selects, active low (bit 0 = LB, bit 1 = UB)
- done  out  1  1 = idle, bus released
- words_written  out  CNT_W  total completed writes; wraps modulo 2^CNT_W

## Operation
- States:
  - IDLE: writeSignal=1, chipEnable=1, data_oe=0, dataBusOutput=0, sram_be_n all 1, done=1, fifo_read=0.
  - SETUP: CE low, WE high, address, data and byte selects stable.
  - WRITE: CE low, WE low.
  - HOLD: CE low, WE high, data still driven.
- Start condition, evaluated in IDLE only: ~empty & valid & ~bus_free. On start:
  - latch fifo_addr, fifo_data and ~fifo_be into the output registers;
  - pulse fifo_read for exactly one cycle;
  - clear burst_cnt and go to SETUP.
- SETUP -> WRITE after 1 cycle.
- WRITE -> HOLD after WE_CYCLES cycles.
- HOLD -> next state after HOLD_CYCLES cycles. On leaving HOLD:
  - words_written increments by 1;
  - if burst_cnt+1 < MAX_BURST and ~empty & valid: latch the next entry, pulse fifo_read, increment burst_cnt, go to SETUP (CE stays low, no IDLE cycle);
  - otherwise go to IDLE.
- bus_free is sampled only at burst start. The framebuffer controller guarantees its grant window covers MAX_BURST*(1+WE_CYCLES+HOLD_CYCLES) cycles. bus_free rising mid-burst does not abort the burst.
- Byte enables: an entry with fifo_be=0 still runs a full cycle with all byte selects high; no bytes change but it counts as written.
- valid=0 with empty=0: treated as not ready; no pop.
- Simultaneous start condition and reset: reset wins.

## Timing
- Reset: next edge forces IDLE outputs, fifo_read=0, words_written=0, burst_cnt=0. A word in flight is abandoned: CE and WE rise together on that edge. If the word was already popped it is lost.
- Edge E0 sees the start condition. In the following cycle: fifo_read=1, chipEnable=0, data_oe=1, writeSignal=1.
- FIFO pops at E1. WE is low from E1 to E1+WE_CYCLES.
- Per-word period: 1+WE_CYCLES+HOLD_CYCLES cycles; 4 with defaults.
- Back-to-back words: the fifo_read pulses of consecutive words are exactly one period apart.
- done falls in the cycle after E0 and rises the cycle after the last HOLD.
- WE never goes low while CE is high. Data changes only in SETUP or IDLE, never while WE is low.

## Test plan
- Single word (default params): FIFO holds addr 0x00010, data 0xBEEF, be=2'b11, bus_free=0.
  - Expect: one fifo_read pulse; WE low for 2 cycles; sram_be_n=2'b00; CE low for 4 cycles; words_written=1; done=1 after.
- Burst limit: 6 entries queued, bus_free=0, MAX_BURST=4.
  - Expect: 4 writes with CE continuously low for 16 cycles, then at least one IDLE cycle, then 2 more writes; words_written=6.
- Bus busy: entries queued, bus_free=1 for 10 cycles.
  - Expect: no fifo_read, CE/WE high, done=1 throughout. Writing starts on the edge after bus_free falls.
- Byte lanes: be=2'b01 then 2'b00.
  - Expect: sram_be_n=2'b10 on the first word, 2'b11 on the second; both complete and words_written increments by 2.
- Reset mid-WRITE: assert reset in the first WRITE cycle.
  - Expect: next edge writeSignal=1, chipEnable=1, data_oe=0, words_written=0; no further fifo_read.
- Parameter sweep: WE_CYCLES=1, HOLD_CYCLES=3, CNT_W=4, 17 words.
  - Expect: period of 5 cycles; words_written wraps to 1.
